// File: rtl/ak4432_audio_rx.sv
// AK4432 serial audio receiver: mode-6 left-justified framing by default, I2S
// framing when AK4432_AUDIO_RX_I2S_EN is defined.
module ak4432_audio_rx #(
    parameter int audio_bits = 16
) (
    input  logic                  mclk,
    input  logic                  reset_n,
    input  logic                  bclk,
    input  logic                  lrclk,
    input  logic                  sdata,
    output logic [audio_bits-1:0] pcm_left,
    output logic [audio_bits-1:0] pcm_right,
    output logic                  valid,
    output logic                  frame_err
);

    typedef enum logic [1:0] {HUNT, LEFT, RIGHT} state_e;

    state_e                state_q, state_d;
    logic [2:0]            bclk_sync_q;
    logic [1:0]            lr_sync_q;
    logic [1:0]            sd_sync_q;
    logic                  lr_prev_q;
    logic                  lr_prev_vld_q;
    logic [31:0]           shreg_q;
    logic [5:0]            cnt_q;
    logic [audio_bits-1:0] hold_q, hold_d;
    logic                  left_ok_q, left_ok_d;
    logic [audio_bits-1:0] pcm_left_q, pcm_left_d;
    logic [audio_bits-1:0] pcm_right_q, pcm_right_d;
    logic                  valid_q, valid_d;
    logic                  frame_err_q, frame_err_d;

    logic                  bit_evt;
    logic                  lr_now;
    logic                  lr_now_vld;
    logic                  ch_left;
    logic                  boundary;
    logic [audio_bits-1:0] captured;

    assign bit_evt  = bclk_sync_q[1] & ~bclk_sync_q[2];
    assign captured = shreg_q[31 -: audio_bits];

`ifdef AK4432_AUDIO_RX_I2S_EN
    // lrclk leads the data by one BCLK, so the word select seen one bit event late lines up with the MSB
    logic lr_dly_q;
    logic lr_dly_vld_q;

    assign lr_now     = lr_dly_q;
    assign lr_now_vld = lr_dly_vld_q;
    assign ch_left    = ~lr_now;

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            lr_dly_q     <= 1'b0;
            lr_dly_vld_q <= 1'b0;
        end else if (bit_evt) begin
            lr_dly_q     <= lr_sync_q[1];
            lr_dly_vld_q <= 1'b1;
        end
    end
`else
    assign lr_now     = lr_sync_q[1];
    assign lr_now_vld = 1'b1;
    assign ch_left    = lr_now;
`endif

    // The first bit event after reset only seeds the word-select history
    assign boundary = bit_evt & lr_now_vld & lr_prev_vld_q & (lr_now != lr_prev_q);

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        left_ok_d   = left_ok_q;
        pcm_left_d  = pcm_left_q;
        pcm_right_d = pcm_right_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
        if (boundary) begin
            case (state_q)
                HUNT: begin
                    if (ch_left) state_d = LEFT;
                end
                LEFT: begin
                    if (!ch_left) begin
                        if (cnt_q == 6'd32) begin
                            hold_d    = captured;
                            left_ok_d = 1'b1;
                            state_d   = RIGHT;
                        end else begin
                            frame_err_d = 1'b1;
                            left_ok_d   = 1'b0;
                            state_d     = HUNT;
                        end
                    end
                end
                RIGHT: begin
                    if (ch_left) begin
                        if ((cnt_q == 6'd32) && left_ok_q) begin
                            pcm_left_d  = hold_q;
                            pcm_right_d = captured;
                            valid_d     = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                        left_ok_d = 1'b0;
                        state_d   = LEFT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= HUNT;
            bclk_sync_q   <= '0;
            lr_sync_q     <= '0;
            sd_sync_q     <= '0;
            lr_prev_q     <= 1'b0;
            lr_prev_vld_q <= 1'b0;
            shreg_q       <= '0;
            cnt_q         <= '0;
            hold_q        <= '0;
            left_ok_q     <= 1'b0;
            pcm_left_q    <= '0;
            pcm_right_q   <= '0;
            valid_q       <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[1:0], bclk};
            lr_sync_q   <= {lr_sync_q[0], lrclk};
            sd_sync_q   <= {sd_sync_q[0], sdata};
            state_q     <= state_d;
            hold_q      <= hold_d;
            left_ok_q   <= left_ok_d;
            pcm_left_q  <= pcm_left_d;
            pcm_right_q <= pcm_right_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            if (bit_evt) begin
                lr_prev_q     <= lr_now;
                lr_prev_vld_q <= lr_now_vld;
                shreg_q       <= {shreg_q[30:0], sd_sync_q[1]};
                if (boundary)            cnt_q <= 6'd1;
                else if (cnt_q != 6'd63) cnt_q <= cnt_q + 6'd1;
            end
        end
    end

    assign pcm_left  = pcm_left_q;
    assign pcm_right = pcm_right_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;

endmodule
